// File: rtl/alu_cmd_sequencer.sv
// Issue/writeback wrapper around a combinational ALU: one command in flight,
// results with derived zero/err flags queued in a fall-through FIFO.
module alu_cmd_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [N-1:0]           cmd_a,
    input  logic [N-1:0]           cmd_b,
    input  logic [3:0]             cmd_op,
    output logic [N-1:0]           alu_inA,
    output logic [N-1:0]           alu_inB,
    output logic [3:0]             alu_op,
    input  logic [N-1:0]           alu_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic                   res_zero,
    output logic                   res_err,
    output logic [3:0]             res_op,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, EXEC} state_e;

    typedef struct packed {
        logic [N-1:0] data;
        logic         zero;
        logic         err;
        logic [3:0]   op;
    } entry_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1100, 4'b1101: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    a_q, b_q;
    logic [3:0]      op_q;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d;
    entry_t          fifo_q [DEPTH];

    logic            accept, cmd_legal, cnt_zero;
    logic            load, push, pop;
    entry_t          push_entry, head;

    assign cmd_ready = (state_q == IDLE) & (level_q < LW'(DEPTH)) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_legal = op_legal(cmd_op);
    assign cnt_zero  = (cnt_q == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && cmd_legal) state_d = EXEC;
            EXEC:    if (cnt_zero)            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Output logic: ALU load, settle counter and FIFO push
    always_comb begin
        load       = 1'b0;
        push       = 1'b0;
        cnt_d      = cnt_q;
        push_entry = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_legal) begin
                        load  = 1'b1;
                        cnt_d = 4'(LAT - 1);
                    end else begin
                        push            = 1'b1;
                        push_entry.zero = 1'b1;
                        push_entry.err  = 1'b1;
                        push_entry.op   = cmd_op;
                    end
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    push            = 1'b1;
                    push_entry.data = alu_out;
                    push_entry.zero = (alu_out == '0);
                    push_entry.op   = op_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // ALU operand registers hold until the next legal accept
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
        end
    end

    assign alu_inA = a_q;
    assign alu_inB = b_q;
    assign alu_op  = op_q;
    assign busy    = (state_q == EXEC);

    assign res_valid = (level_q != '0);
    assign pop       = res_valid & res_ready;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage needs no reset: head outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= push_entry;
    end

    assign head     = fifo_q[rptr_q];
    assign res_data = res_valid ? head.data : '0;
    assign res_zero = res_valid ? head.zero : 1'b0;
    assign res_err  = res_valid ? head.err  : 1'b0;
    assign res_op   = res_valid ? head.op   : 4'b0000;
    assign level    = level_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: one sequencer with LAT=1 and one with LAT=3, each driving a
// behavioural ALU, checked with immediate assertions.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return {31'b0, $signed(a) < $signed(b)};
            4'b1100: return ~(a | b);
            4'b1101: return {a[15:0], b[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] d1_a, d1_b, d1_aluA, d1_aluB, d1_aluout, d1_rdata;
    logic [3:0]  d1_op, d1_aluop, d1_rop;
    logic        d1_valid, d1_ready, d1_rvalid, d1_rready, d1_rzero, d1_rerr, d1_busy;
    logic [2:0]  d1_level;

    logic [31:0] d3_a, d3_b, d3_aluA, d3_aluB, d3_aluout, d3_rdata;
    logic [3:0]  d3_op, d3_aluop, d3_rop;
    logic        d3_valid, d3_ready, d3_rvalid, d3_rready, d3_rzero, d3_rerr, d3_busy;
    logic [2:0]  d3_level;

    assign d1_aluout = alu_f(d1_aluA, d1_aluB, d1_aluop);
    assign d3_aluout = alu_f(d3_aluA, d3_aluB, d3_aluop);

    alu_cmd_sequencer #(.N(32), .DEPTH(4), .LAT(1)) u_d1 (
        .clk(clk), .rst(rst),
        .cmd_valid(d1_valid), .cmd_ready(d1_ready),
        .cmd_a(d1_a), .cmd_b(d1_b), .cmd_op(d1_op),
        .alu_inA(d1_aluA), .alu_inB(d1_aluB), .alu_op(d1_aluop), .alu_out(d1_aluout),
        .res_valid(d1_rvalid), .res_ready(d1_rready), .res_data(d1_rdata),
        .res_zero(d1_rzero), .res_err(d1_rerr), .res_op(d1_rop),
        .busy(d1_busy), .level(d1_level)
    );

    alu_cmd_sequencer #(.N(32), .DEPTH(4), .LAT(3)) u_d3 (
        .clk(clk), .rst(rst),
        .cmd_valid(d3_valid), .cmd_ready(d3_ready),
        .cmd_a(d3_a), .cmd_b(d3_b), .cmd_op(d3_op),
        .alu_inA(d3_aluA), .alu_inB(d3_aluB), .alu_op(d3_aluop), .alu_out(d3_aluout),
        .res_valid(d3_rvalid), .res_ready(d3_rready), .res_data(d3_rdata),
        .res_zero(d3_rzero), .res_err(d3_rerr), .res_op(d3_rop),
        .busy(d3_busy), .level(d3_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        d1_valid = 0; d1_a = 0; d1_b = 0; d1_op = 0; d1_rready = 0;
        d3_valid = 0; d3_a = 0; d3_b = 0; d3_op = 0; d3_rready = 0;
        tick(); tick();
        chk("rst_level", 32'(d1_level), 0);
        chk("rst_rvalid", 32'(d1_rvalid), 0);
        chk("rst_cmd_ready", 32'(d1_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(d1_ready), 1);
        chk("post_rst_aluA", d1_aluA, 0);
        chk("post_rst_busy", 32'(d1_busy), 0);
        chk("post_rst_rdata", d1_rdata, 0);

        // ADD 5+7, LAT=1
        d1_a = 5; d1_b = 7; d1_op = 4'b0010; d1_valid = 1;
        tick();
        d1_valid = 0;
        chk("add_aluA", d1_aluA, 5);
        chk("add_aluB", d1_aluB, 7);
        chk("add_busy", 32'(d1_busy), 1);
        chk("add_ready_exec", 32'(d1_ready), 0);
        chk("add_not_early", 32'(d1_level), 0);
        tick();
        chk("add_rvalid", 32'(d1_rvalid), 1);
        chk("add_data", d1_rdata, 12);
        chk("add_zero", 32'(d1_rzero), 0);
        chk("add_err", 32'(d1_rerr), 0);
        chk("add_level1", 32'(d1_level), 1);
        d1_rready = 1;
        tick();
        d1_rready = 0;
        chk("add_level0", 32'(d1_level), 0);

        // SUB to zero
        d1_a = 9; d1_b = 9; d1_op = 4'b0110; d1_valid = 1;
        tick();
        d1_valid = 0;
        tick();
        chk("sub_data", d1_rdata, 0);
        chk("sub_zero", 32'(d1_rzero), 1);
        chk("sub_op", 32'(d1_rop), 32'h6);
        chk("sub_err", 32'(d1_rerr), 0);
        d1_rready = 1;
        tick();
        d1_rready = 0;
        chk("sub_drained", 32'(d1_level), 0);

        // Illegal op then AND, back to back
        d1_a = 32'h1234; d1_b = 32'h5678; d1_op = 4'b0011; d1_valid = 1;
        tick();
        chk("ill_rvalid", 32'(d1_rvalid), 1);
        chk("ill_data", d1_rdata, 0);
        chk("ill_zero", 32'(d1_rzero), 1);
        chk("ill_err", 32'(d1_rerr), 1);
        chk("ill_op", 32'(d1_rop), 3);
        chk("ill_ready", 32'(d1_ready), 1);
        chk("ill_alu_untouched", d1_aluA, 9);
        d1_a = 32'hF0F0_F0F0; d1_b = 32'hFF00_FF00; d1_op = 4'b0000;
        tick();
        d1_valid = 0;
        chk("and_busy", 32'(d1_busy), 1);
        chk("and_head_still_ill", 32'(d1_rop), 3);
        tick();
        chk("and_level2", 32'(d1_level), 2);
        d1_rready = 1;
        tick();
        chk("and_data", d1_rdata, 32'hF000_F000);
        chk("and_err", 32'(d1_rerr), 0);
        chk("and_zero", 32'(d1_rzero), 0);
        chk("and_level1", 32'(d1_level), 1);
        tick();
        d1_rready = 0;
        chk("and_level0", 32'(d1_level), 0);

        // Backpressure: four ADDs fill the FIFO, fifth is held
        for (int i = 1; i <= 4; i++) begin
            d1_a = 32'(i); d1_b = 32'h10; d1_op = 4'b0010; d1_valid = 1;
            tick();
            d1_valid = 0;
            tick();
        end
        chk("bp_level_full", 32'(d1_level), 4);
        chk("bp_ready_low", 32'(d1_ready), 0);
        d1_a = 5; d1_valid = 1;
        tick(); tick();
        chk("bp_held_ready", 32'(d1_ready), 0);
        chk("bp_held_busy", 32'(d1_busy), 0);
        chk("bp_held_aluA", d1_aluA, 4);
        chk("bp_head1", d1_rdata, 32'h11);
        d1_rready = 1;
        tick();
        d1_rready = 0;
        chk("bp_level3", 32'(d1_level), 3);
        chk("bp_ready_back", 32'(d1_ready), 1);
        tick();
        d1_valid = 0;
        chk("bp_5th_aluA", d1_aluA, 5);
        tick();
        chk("bp_level_refull", 32'(d1_level), 4);
        d1_rready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_order", d1_rdata, 32'h12 + 32'(k));
            tick();
        end
        d1_rready = 0;
        chk("bp_empty", 32'(d1_level), 0);

        // LAT=3 SLT 2<3
        d3_a = 2; d3_b = 3; d3_op = 4'b0111; d3_valid = 1;
        tick();
        d3_valid = 0;
        for (int c = 0; c < 3; c++) begin
            chk("slt_busy", 32'(d3_busy), 1);
            chk("slt_ready_low", 32'(d3_ready), 0);
            chk("slt_no_push", 32'(d3_level), 0);
            tick();
        end
        chk("slt_busy_done", 32'(d3_busy), 0);
        chk("slt_level", 32'(d3_level), 1);
        chk("slt_data", d3_rdata, 1);
        chk("slt_op", 32'(d3_rop), 7);
        d3_rready = 1;
        tick();
        d3_rready = 0;
        chk("slt_drained", 32'(d3_level), 0);

        // Reset in the middle of EXEC with two queued entries
        d3_op = 4'b1111; d3_valid = 1;
        tick();
        d3_op = 4'b0011;
        tick();
        d3_a = 1; d3_b = 1; d3_op = 4'b0010;
        tick();
        d3_valid = 0;
        chk("mid_level2", 32'(d3_level), 2);
        chk("mid_busy", 32'(d3_busy), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_ready_in_rst", 32'(d3_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_level0", 32'(d3_level), 0);
        chk("mid_rvalid", 32'(d3_rvalid), 0);
        chk("mid_aluA", d3_aluA, 0);
        chk("mid_aluB", d3_aluB, 0);
        chk("mid_aluop", 32'(d3_aluop), 0);
        chk("mid_busy0", 32'(d3_busy), 0);
        chk("mid_ready1", 32'(d3_ready), 1);
        tick(); tick(); tick();
        chk("mid_no_late_push", 32'(d3_level), 0);
        chk("mid_no_late_valid", 32'(d3_rvalid), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
